instruction_fetch: RTL

Reads instruction bytes out of the 8-bit `RAM` and hands complete instructions to the decode/execute stage over a valid/ready handshake. It is the stage directly downstream of `RAM`: it drives the RAM `address` port and consumes RAM `data_out`. It also owns the program counter and supports taken jumps and a halt opcode. The RAM `write_enable` is not driven by this block; the top level arbitrates writes.

---
 rtl/instruction_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: reads opcode/operand bytes from a registered-read RAM and
// presents whole instructions on a valid/ready handshake; owns the PC.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] HLT_OPCODE = 8'h7F
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] ram_address,
  input  logic [7:0] ram_data,
  output logic       instr_valid,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  input  logic       instr_ready,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  output logic       halted
);

  typedef enum logic [2:0] {
    ADDR_OP,
    LATCH_OP,
    ADDR_OPR,
    LATCH_OPR,
    HOLD,
    HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ADDR_OP;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    // A jump overrides everything, including a handshake completing in HOLD.
    if (jump_en) begin
      pc_d    = jump_addr;
      state_d = ADDR_OP;
    end else begin
      case (state_q)
        ADDR_OP:  state_d = LATCH_OP;
        LATCH_OP: begin
          opcode_d = ram_data;
          ipc_d    = pc_q;
          pc_d     = pc_q + 8'd1;
          if (ram_data[7]) begin
            state_d = ADDR_OPR;
          end else begin
            operand_d = '0;
            state_d   = HOLD;
          end
        end
        ADDR_OPR: state_d = LATCH_OPR;
        LATCH_OPR: begin
          operand_d = ram_data;
          pc_d      = pc_q + 8'd1;
          state_d   = HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = (opcode_q == HLT_OPCODE) ? HALTED : ADDR_OP;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = ADDR_OP;
      endcase
    end
  end

  assign ram_address   = pc_q;
  assign instr_valid   = (state_q == HOLD);
  assign halted        = (state_q == HALTED);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;

endmodule
